// File: rtl/h80bus_arbiter.sv
// h80 bus arbiter: two-master round-robin sequencer
// driving the shared slave bus (ce_n/addr/cmd/data_).
module h80bus_arbiter #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16,
    parameter int WAIT_LIMIT     = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_req,
    input  logic [BUS_ADDR_WIDTH-1:0] m0_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m0_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] m0_wdata,
    output logic [BUS_DATA_WIDTH-1:0] m0_rdata,
    output logic                      m0_ack,
    output logic                      m0_err,
    input  logic                      m1_req,
    input  logic [BUS_ADDR_WIDTH-1:0] m1_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m1_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] m1_wdata,
    output logic [BUS_DATA_WIDTH-1:0] m1_rdata,
    output logic                      m1_ack,
    output logic                      m1_err,
    output logic                      ce_n,
    output logic [BUS_ADDR_WIDTH-1:0] addr,
    output logic [BUS_CMD_WIDTH-1:0]  cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] data_,
    input  logic                      wait_n,
    output logic                      owner
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_LIMIT - 1);
    localparam bit WD_EN = (WAIT_LIMIT != 0);

    typedef enum logic [1:0] {IDLE, A1, A2, DONE} state_t;

    state_t                    state_q, state_d;
    logic                      owner_q;
    logic [BUS_ADDR_WIDTH-1:0] addr_q;
    logic [BUS_CMD_WIDTH-1:0]  cmd_q;
    logic [BUS_DATA_WIDTH-1:0] wdata_q;
    logic [BUS_DATA_WIDTH-1:0] rdata0_q, rdata1_q;
    logic [CW-1:0]             cnt_q;
    logic                      err_q;
    logic                      pick;
    logic                      hit;
    logic                      drive;

    // On a tie the master that was not served last wins.
    assign pick = (m0_req && m1_req) ? ~owner_q : m1_req;
    assign hit  = WD_EN && (cnt_q == CNT_MAX);

    // Next-state logic for the bus sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (m0_req || m1_req) state_d = A1;
            A1:   state_d = A2;
            A2:   if (wait_n || hit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Request latch, read capture and wait watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= 1'b1;
            addr_q   <= '0;
            cmd_q    <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner_q <= pick;
                        addr_q  <= pick ? m1_addr  : m0_addr;
                        cmd_q   <= pick ? m1_cmd   : m0_cmd;
                        wdata_q <= pick ? m1_wdata : m0_wdata;
                    end
                end
                A2: begin
                    if (wait_n) begin
                        if (cmd_q[0] && owner_q)  rdata1_q <= data_;
                        if (cmd_q[0] && !owner_q) rdata0_q <= data_;
                    end else if (hit) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ce_n  = !(state_q == A1 || state_q == A2);
    assign drive = !ce_n && !cmd_q[0];
    assign data_ = drive ? wdata_q : {BUS_DATA_WIDTH{1'bz}};
    assign addr  = addr_q;
    assign cmd   = cmd_q;
    assign owner = owner_q;

    assign m0_ack   = (state_q == DONE) && !owner_q;
    assign m1_ack   = (state_q == DONE) && owner_q;
    assign m0_err   = m0_ack && err_q;
    assign m1_err   = m1_ack && err_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_h80bus_arbiter.sv
// Directed bench for h80bus_arbiter: default instance plus
// a WAIT_LIMIT=4 instance for the watchdog case.
module tb_h80bus_arbiter;

    logic        clk = 0;
    logic        reset = 1;
    logic        m0_req = 0, m1_req = 0;
    logic [15:0] m0_addr = 0, m1_addr = 0;
    logic [2:0]  m0_cmd = 0, m1_cmd = 0;
    logic [15:0] m0_wdata = 0, m1_wdata = 0;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic        ce_n;
    logic [15:0] addr;
    logic [2:0]  cmd;
    wire  [15:0] data_;
    logic        wait_n = 1;
    logic        owner;

    logic        w_m0_req = 0;
    logic [15:0] w_m0_rdata, w_m1_rdata;
    logic        w_m0_ack, w_m1_ack, w_m0_err, w_m1_err;
    logic        w_ce_n;
    logic [15:0] w_addr;
    logic [2:0]  w_cmd;
    wire  [15:0] w_data_;
    logic        w_owner;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    h80bus_arbiter u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_cmd(m1_cmd),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .ce_n(ce_n), .addr(addr), .cmd(cmd), .data_(data_),
        .wait_n(wait_n), .owner(owner)
    );

    h80bus_arbiter #(.WAIT_LIMIT(4)) u_wd (
        .clk(clk), .reset(reset),
        .m0_req(w_m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd),
        .m0_wdata(m0_wdata), .m0_rdata(w_m0_rdata),
        .m0_ack(w_m0_ack), .m0_err(w_m0_err),
        .m1_req(1'b0), .m1_addr(16'h0), .m1_cmd(3'h0),
        .m1_wdata(16'h0), .m1_rdata(w_m1_rdata),
        .m1_ack(w_m1_ack), .m1_err(w_m1_err),
        .ce_n(w_ce_n), .addr(w_addr), .cmd(w_cmd), .data_(w_data_),
        .wait_n(wait_n), .owner(w_owner)
    );

    // Slave model: registered read, write on every ce_n-low edge.
    logic [15:0] mem [0:255];
    logic [15:0] rd_q = 0;
    always @(posedge clk) begin
        if (reset) begin
            mem[8'h10] <= 16'h1234;
        end else if (!ce_n) begin
            if (cmd[0]) rd_q <= mem[addr[7:0]];
            else        mem[addr[7:0]] <= data_;
        end
    end
    assign data_   = (!ce_n && cmd[0]) ? rd_q : 16'hzzzz;
    assign w_data_ = (!w_ce_n && w_cmd[0]) ? 16'h5A5A : 16'hzzzz;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xact(input bit m, input logic [15:0] a,
                        input logic [2:0] c, input logic [15:0] wd,
                        input int stalls, output int cyc,
                        output int ce_low, output int drv,
                        output logic [15:0] rd, output logic er,
                        output int oth);
        int  left;
        bit  got;
        @(negedge clk);
        wait_n = 1;
        if (m) begin
            m1_req = 1; m1_addr = a; m1_cmd = c; m1_wdata = wd;
        end else begin
            m0_req = 1; m0_addr = a; m0_cmd = c; m0_wdata = wd;
        end
        cyc = 0; ce_low = 0; drv = 0; oth = 0;
        rd = '0; er = 0; left = stalls; got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!ce_n) begin
                ce_low++;
                if (data_ == wd) drv++;
            end
            if (cyc >= 2 && left > 0) begin
                wait_n = 0;
                left--;
            end else begin
                wait_n = 1;
            end
            if (m ? m0_ack : m1_ack) oth++;
            if (m ? m1_ack : m0_ack) begin
                got = 1;
                rd  = m ? m1_rdata : m0_rdata;
                er  = m ? m1_err : m0_err;
                if (m) m1_req = 0;
                else   m0_req = 0;
            end
        end
        wait_n = 1;
        if (!got) chk("xact_bound", 0, 1);
    endtask

    initial begin
        int cyc, ce_low, drv, oth, n, t0;
        logic [15:0] rd;
        logic er;
        int  gcyc [4];
        bit  gm [4];
        bit  gown [4];
        bit  up0, up1;

        repeat (3) @(negedge clk);
        reset = 0;
        chk("rst_ce_n", ce_n, 1);
        chk("rst_addr", addr, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        chk("rst_owner", owner, 1);

        xact(0, 16'h0010, 3'b001, 16'h0, 0, cyc, ce_low, drv, rd, er, oth);
        chk("rd0_cycles", cyc, 3);
        chk("rd0_ce_low", ce_low, 2);
        chk("rd0_data", rd, 16'h1234);
        chk("rd0_err", er, 0);
        chk("rd0_other", oth, 0);
        chk("rd0_owner", owner, 0);

        xact(1, 16'h0020, 3'b000, 16'hBEEF, 0, cyc, ce_low, drv, rd, er, oth);
        chk("wr1_cycles", cyc, 3);
        chk("wr1_ce_low", ce_low, 2);
        chk("wr1_drive", drv, 2);
        chk("wr1_owner", owner, 1);
        chk("wr1_rdata_keep", m1_rdata, 0);
        xact(1, 16'h0020, 3'b001, 16'h0, 0, cyc, ce_low, drv, rd, er, oth);
        chk("rd1_data", rd, 16'hBEEF);
        chk("rd1_cycles", cyc, 3);

        xact(1, 16'h0010, 3'b001, 16'h0, 5, cyc, ce_low, drv, rd, er, oth);
        chk("stall_ce_low", ce_low, 7);
        chk("stall_cycles", cyc, 8);
        chk("stall_err", er, 0);
        chk("stall_data", rd, 16'h1234);

        // Watchdog instance: one good read, then a timed-out one.
        @(negedge clk);
        w_m0_req = 1; m0_addr = 16'h0040; m0_cmd = 3'b001;
        n = 0;
        while (!w_m0_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        w_m0_req = 0;
        chk("wd_ok_cycles", n, 3);
        chk("wd_ok_data", w_m0_rdata, 16'h5A5A);
        chk("wd_ok_err", w_m0_err, 0);
        @(negedge clk);
        w_m0_req = 1;
        n = 0; ce_low = 0;
        while (!w_m0_ack && n < 20) begin
            @(negedge clk);
            n++;
            if (!w_ce_n) ce_low++;
            wait_n = (n >= 2) ? 1'b0 : 1'b1;
        end
        w_m0_req = 0;
        chk("wd_to_cycles", n, 6);
        chk("wd_to_ce_low", ce_low, 5);
        chk("wd_to_err", w_m0_err, 1);
        chk("wd_to_ce_n", w_ce_n, 1);
        chk("wd_to_data", w_m0_rdata, 16'h5A5A);
        wait_n = 1;
        @(negedge clk);
        chk("wd_to_ack_gone", {w_m0_ack, w_m0_err}, 0);

        // Reset while an m0 write stalls in A2.
        @(negedge clk);
        m0_req = 1; m0_addr = 16'h0030; m0_cmd = 3'b000;
        m0_wdata = 16'h7777;
        @(negedge clk);
        wait_n = 0;
        @(negedge clk);
        chk("abort_in_a2", ce_n, 0);
        chk("abort_owner_pre", owner, 0);
        reset = 1;
        m0_req = 0;
        @(negedge clk);
        reset = 0;
        wait_n = 1;
        chk("abort_ce_n", ce_n, 1);
        chk("abort_ack", m0_ack, 0);
        chk("abort_owner", owner, 1);
        xact(0, 16'h0010, 3'b001, 16'h0, 0, cyc, ce_low, drv, rd, er, oth);
        chk("post_rst_cycles", cyc, 3);
        chk("post_rst_data", rd, 16'h1234);

        // Round robin from reset with both masters requesting.
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        m0_addr = 16'h0010; m0_cmd = 3'b001;
        m1_addr = 16'h0020; m1_cmd = 3'b001;
        m0_req = 1; m1_req = 1;
        n = 0; t0 = 0; up0 = 0; up1 = 0;
        while (n < 4 && t0 < 60) begin
            @(negedge clk);
            t0++;
            if (up0) begin m0_req = 1; up0 = 0; end
            if (up1) begin m1_req = 1; up1 = 0; end
            if (m0_ack && m1_ack) chk("rr_double_ack", 1, 0);
            if (m0_ack || m1_ack) begin
                gcyc[n] = t0;
                gm[n]   = m1_ack;
                gown[n] = owner;
                n++;
                if (m0_ack) begin m0_req = 0; up0 = 1; end
                else        begin m1_req = 0; up1 = 1; end
            end
        end
        m0_req = 0; m1_req = 0;
        chk("rr_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                chk($sformatf("rr_grant%0d", i), gm[i], i % 2);
                chk($sformatf("rr_owner%0d", i), gown[i], i % 2);
                chk($sformatf("rr_cycle%0d", i), gcyc[i], 3 + 4 * i);
            end
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
